// File: rtl/udp_echo_responder.sv
// UDP echo application: parses the rx header, filters on destination port,
// buffers the payload in a local FIFO and replays it to the sender.
module udp_echo_responder #(
    parameter logic [15:0] LISTEN_PORT = 16'd0,
    parameter int          MODE        = 0,
    parameter logic [15:0] PORT_OFFSET = 16'd1,
    parameter logic [15:0] REPLY_PORT  = 16'd11451,
    parameter int          DEPTH       = 2048
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_head_av_i,
    input  logic [31:0] rx_head_i,
    output logic        rx_head_rdy_o,
    input  logic        rx_data_av_i,
    input  logic [7:0]  rx_data_i,
    output logic        rx_data_rdy_o,
    output logic [31:0] tx_ip_o,
    output logic [15:0] tx_dst_port_o,
    output logic [7:0]  tx_data_o,
    output logic        tx_data_av_o,
    input  logic        tx_data_rdy_i,
    output logic        tx_req_o,
    input  logic        tx_req_rdy_i,
    output logic [15:0] echo_cnt_o,
    output logic [15:0] drop_cnt_o
);

    localparam int          AW      = $clog2(DEPTH);
    localparam logic [16:0] MAX_LEN = 17'(DEPTH + 8);

    typedef enum logic [2:0] {IDLE, HEAD, RECV, DROP, PUSH, REQ} state_t;

    state_t       state_reg;
    logic [1:0]   word_cnt_reg;
    logic [15:0]  rem_reg;
    logic [15:0]  dport_reg;
    logic [AW:0]  wr_ptr_reg;
    logic [AW:0]  rd_ptr_reg;
    logic [7:0]   rd_data_reg;
    logic [7:0]   mem [DEPTH];

    logic         head_fire;
    logic         data_fire;
    logic         fifo_empty;
    logic         out_free;
    logic         rd_en;
    logic         frame_bad;
    logic [15:0]  udp_len;

    assign head_fire  = rx_head_av_i && rx_head_rdy_o;
    assign data_fire  = rx_data_av_i && rx_data_rdy_o;
    assign fifo_empty = (wr_ptr_reg == rd_ptr_reg);
    // Output slot can take a new byte when empty or being consumed this cycle.
    assign out_free   = !tx_data_av_o || tx_data_rdy_i;
    assign rd_en      = (state_reg == PUSH) && out_free && !fifo_empty;
    assign udp_len    = rx_head_i[15:0];
    assign frame_bad  = ((LISTEN_PORT != 16'd0) && (dport_reg != LISTEN_PORT))
                      || (udp_len <= 16'd8)
                      || ({1'b0, udp_len} > MAX_LEN);
    assign tx_data_o  = rd_data_reg;

    always_ff @(posedge clk) begin
        if ((state_reg == RECV) && data_fire) begin
            mem[wr_ptr_reg[AW-1:0]] <= rx_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_reg <= 8'd0;
        end else if (rd_en) begin
            rd_data_reg <= mem[rd_ptr_reg[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg     <= IDLE;
            word_cnt_reg  <= 2'd0;
            rem_reg       <= 16'd0;
            dport_reg     <= 16'd0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            rx_head_rdy_o <= 1'b0;
            rx_data_rdy_o <= 1'b0;
            tx_ip_o       <= 32'd0;
            tx_dst_port_o <= 16'd0;
            tx_data_av_o  <= 1'b0;
            tx_req_o      <= 1'b0;
            echo_cnt_o    <= 16'd0;
            drop_cnt_o    <= 16'd0;
        end else begin
            tx_req_o <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (rx_head_av_i) begin
                        state_reg     <= HEAD;
                        rx_head_rdy_o <= 1'b1;
                        word_cnt_reg  <= 2'd0;
                    end
                end
                HEAD: begin
                    if (head_fire) begin
                        word_cnt_reg <= word_cnt_reg + 2'd1;
                        case (word_cnt_reg)
                            2'd0: tx_ip_o <= rx_head_i;
                            2'd2: begin
                                dport_reg     <= rx_head_i[15:0];
                                tx_dst_port_o <= (MODE == 0) ? rx_head_i[31:16] + PORT_OFFSET
                                                             : REPLY_PORT;
                            end
                            2'd3: begin
                                rx_head_rdy_o <= 1'b0;
                                // Short/negative payloads leave nothing to drain.
                                rem_reg <= (udp_len > 16'd8) ? udp_len - 16'd8 : 16'd0;
                                if (frame_bad) begin
                                    state_reg     <= DROP;
                                    rx_data_rdy_o <= (udp_len > 16'd8);
                                end else begin
                                    state_reg     <= RECV;
                                    rx_data_rdy_o <= 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                RECV: begin
                    if (data_fire) begin
                        wr_ptr_reg <= wr_ptr_reg + 1'b1;
                        rem_reg    <= rem_reg - 16'd1;
                        if (rem_reg == 16'd1) begin
                            rx_data_rdy_o <= 1'b0;
                            state_reg     <= PUSH;
                        end
                    end
                end
                DROP: begin
                    if ((rem_reg == 16'd0) || (data_fire && (rem_reg == 16'd1))) begin
                        rem_reg       <= 16'd0;
                        rx_data_rdy_o <= 1'b0;
                        state_reg     <= IDLE;
                        if (drop_cnt_o != 16'hFFFF) begin
                            drop_cnt_o <= drop_cnt_o + 16'd1;
                        end
                    end else if (data_fire) begin
                        rem_reg <= rem_reg - 16'd1;
                    end
                end
                PUSH: begin
                    if (out_free) begin
                        if (!fifo_empty) begin
                            tx_data_av_o <= 1'b1;
                            rd_ptr_reg   <= rd_ptr_reg + 1'b1;
                        end else begin
                            tx_data_av_o <= 1'b0;
                            state_reg    <= REQ;
                        end
                    end
                end
                REQ: begin
                    if (tx_req_rdy_i) begin
                        tx_req_o  <= 1'b1;
                        state_reg <= IDLE;
                        if (echo_cnt_o != 16'hFFFF) begin
                            echo_cnt_o <= echo_cnt_o + 16'd1;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_echo_responder.sv
// Bench for udp_echo_responder: two instances (MODE0 with port filter, MODE1 accept-any)
// driven with random frames and compared against a frame-level reference model.
module tb_udp_echo_responder;

    localparam int          DEPTH   = 16;
    localparam logic [15:0] LISTEN0 = 16'd1234;
    localparam logic [15:0] OFFSET0 = 16'd1;
    localparam logic [15:0] REPLY1  = 16'd11451;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        rx_head_av  [2];
    logic [31:0] rx_head     [2];
    logic        rx_head_rdy [2];
    logic        rx_data_av  [2];
    logic [7:0]  rx_data     [2];
    logic        rx_data_rdy [2];
    logic [31:0] tx_ip       [2];
    logic [15:0] tx_dst_port [2];
    logic [7:0]  tx_data     [2];
    logic        tx_data_av  [2];
    logic        tx_data_rdy [2];
    logic        tx_req      [2];
    logic        tx_req_rdy  [2];
    logic [15:0] echo_cnt    [2];
    logic [15:0] drop_cnt    [2];

    udp_echo_responder #(
        .LISTEN_PORT(LISTEN0), .MODE(0), .PORT_OFFSET(OFFSET0),
        .REPLY_PORT(REPLY1), .DEPTH(DEPTH)
    ) dut0 (
        .clk(clk), .rst(rst),
        .rx_head_av_i(rx_head_av[0]), .rx_head_i(rx_head[0]), .rx_head_rdy_o(rx_head_rdy[0]),
        .rx_data_av_i(rx_data_av[0]), .rx_data_i(rx_data[0]), .rx_data_rdy_o(rx_data_rdy[0]),
        .tx_ip_o(tx_ip[0]), .tx_dst_port_o(tx_dst_port[0]), .tx_data_o(tx_data[0]),
        .tx_data_av_o(tx_data_av[0]), .tx_data_rdy_i(tx_data_rdy[0]),
        .tx_req_o(tx_req[0]), .tx_req_rdy_i(tx_req_rdy[0]),
        .echo_cnt_o(echo_cnt[0]), .drop_cnt_o(drop_cnt[0])
    );

    udp_echo_responder #(
        .LISTEN_PORT(16'd0), .MODE(1), .PORT_OFFSET(OFFSET0),
        .REPLY_PORT(REPLY1), .DEPTH(DEPTH)
    ) dut1 (
        .clk(clk), .rst(rst),
        .rx_head_av_i(rx_head_av[1]), .rx_head_i(rx_head[1]), .rx_head_rdy_o(rx_head_rdy[1]),
        .rx_data_av_i(rx_data_av[1]), .rx_data_i(rx_data[1]), .rx_data_rdy_o(rx_data_rdy[1]),
        .tx_ip_o(tx_ip[1]), .tx_dst_port_o(tx_dst_port[1]), .tx_data_o(tx_data[1]),
        .tx_data_av_o(tx_data_av[1]), .tx_data_rdy_i(tx_data_rdy[1]),
        .tx_req_o(tx_req[1]), .tx_req_rdy_i(tx_req_rdy[1]),
        .echo_cnt_o(echo_cnt[1]), .drop_cnt_o(drop_cnt[1])
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit bp_en    = 1'b0;
    bit gap_en   = 1'b0;
    int m_echo [2] = '{0, 0};
    int m_drop [2] = '{0, 0};

    logic [7:0]  got_q0 [$];
    logic [7:0]  got_q1 [$];
    int          req_cnt  [2] = '{0, 0};
    int          dbl_req  [2] = '{0, 0};
    logic        prev_req [2] = '{1'b0, 1'b0};
    logic [31:0] req_ip   [2];
    logic [15:0] req_port [2];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Tx-side observer: records every byte/request handshake as seen by the core.
    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (tx_data_av[d] === 1'b1 && tx_data_rdy[d] === 1'b1) begin
                    if (d == 0) got_q0.push_back(tx_data[0]);
                    else        got_q1.push_back(tx_data[1]);
                end
                if (tx_req[d] === 1'b1) begin
                    req_cnt[d]++;
                    req_ip[d]   = tx_ip[d];
                    req_port[d] = tx_dst_port[d];
                    if (prev_req[d]) dbl_req[d]++;
                end
                prev_req[d] = (tx_req[d] === 1'b1);
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            for (int d = 0; d < 2; d++) begin
                tx_data_rdy[d] = bp_en ? ($urandom_range(0, 1) == 1) : 1'b1;
                tx_req_rdy[d]  = bp_en ? ($urandom_range(0, 3) == 0) : 1'b1;
            end
        end
    end

    function automatic int got_size(input int d);
        return (d == 0) ? got_q0.size() : got_q1.size();
    endfunction

    function automatic logic [7:0] got_at(input int d, input int i);
        return (d == 0) ? got_q0[i] : got_q1[i];
    endfunction

    task automatic send_word(input int d, input logic [31:0] w, output bit ok);
        if (gap_en && $urandom_range(0, 3) == 0) begin
            rx_head_av[d] = 1'b0;
            @(posedge clk);
            #1;
        end
        rx_head_av[d] = 1'b1;
        rx_head[d]    = w;
        ok = 1'b0;
        for (int b = 0; b < 200; b++) begin
            @(negedge clk);
            if (rx_head_rdy[d]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_head_av[d] = 1'b0;
    endtask

    task automatic send_byte(input int d, input logic [7:0] b, output bit ok);
        if (gap_en && $urandom_range(0, 3) == 0) begin
            rx_data_av[d] = 1'b0;
            @(posedge clk);
            #1;
        end
        rx_data_av[d] = 1'b1;
        rx_data[d]    = b;
        ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rx_data_rdy[d]) begin
                ok = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        rx_data_av[d] = 1'b0;
    endtask

    task automatic send_header(input int d, input logic [31:0] src_ip, input logic [15:0] sport,
                               input logic [15:0] dport, input logic [15:0] udp_len, output bit ok);
        logic [31:0] words [4];
        words[0] = src_ip;
        words[1] = 32'h0A000001;
        words[2] = {sport, dport};
        words[3] = {16'($urandom), udp_len};
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit w_ok;
            send_word(d, words[i], w_ok);
            if (!w_ok) begin
                check_val("head_accept", 32'd0, 32'd1);
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic run_frame(input int d, input logic [31:0] src_ip, input logic [15:0] sport,
                             input logic [15:0] dport, input logic [15:0] udp_len, input bit rnd_pl);
        logic [7:0]  exp_q [$];
        int          n_bytes;
        int          n_acc;
        int          req0;
        bit          exp_drop;
        int          listen;
        logic [15:0] exp_port;
        bit          ok;

        listen   = (d == 0) ? int'(LISTEN0) : 0;
        n_bytes  = (int'(udp_len) > 8) ? int'(udp_len) - 8 : 0;
        exp_drop = (listen != 0 && int'(dport) != listen) || int'(udp_len) <= 8 || n_bytes > DEPTH;
        exp_port = (d == 0) ? 16'((int'(sport) + int'(OFFSET0)) % 65536) : REPLY1;
        for (int i = 0; i < n_bytes; i++) exp_q.push_back(rnd_pl ? 8'($urandom) : 8'(i + 1));

        if (d == 0) got_q0.delete();
        else        got_q1.delete();
        req0 = req_cnt[d];

        send_header(d, src_ip, sport, dport, udp_len, ok);
        if (!ok) return;
        n_acc = 0;
        for (int i = 0; i < n_bytes; i++) begin
            send_byte(d, exp_q[i], ok);
            if (!ok) break;
            n_acc++;
        end
        check_val("rx_consumed", n_acc, n_bytes);

        if (exp_drop) begin
            if (m_drop[d] < 65535) m_drop[d]++;
            repeat (12) @(negedge clk);
            check_val("drop_no_tx_bytes", got_size(d), 0);
            check_val("drop_no_req", req_cnt[d] - req0, 0);
        end else begin
            if (m_echo[d] < 65535) m_echo[d]++;
            for (int c = 0; c < 3000 && req_cnt[d] == req0; c++) @(negedge clk);
            repeat (3) @(negedge clk);
            check_val("req_count", req_cnt[d] - req0, 1);
            check_val("req_single", dbl_req[d], 0);
            check_val("tx_ip", req_ip[d], src_ip);
            check_val("tx_port", {16'd0, req_port[d]}, {16'd0, exp_port});
            check_val("tx_len", got_size(d), n_bytes);
            if (got_size(d) == n_bytes) begin
                for (int i = 0; i < n_bytes; i++) check_val("tx_byte", {24'd0, got_at(d, i)}, {24'd0, exp_q[i]});
            end
        end
        check_val("echo_cnt", {16'd0, echo_cnt[d]}, m_echo[d]);
        check_val("drop_cnt", {16'd0, drop_cnt[d]}, m_drop[d]);
        $display("frame dut%0d src=%h:%0d dst_port=%0d udp_len=%0d %s", d, src_ip, sport, dport,
                 udp_len, exp_drop ? "dropped" : "echoed");
    endtask

    task automatic check_idle_outputs(input int d);
        check_val("rst_head_rdy", {31'd0, rx_head_rdy[d]}, 0);
        check_val("rst_data_rdy", {31'd0, rx_data_rdy[d]}, 0);
        check_val("rst_tx_ip", tx_ip[d], 0);
        check_val("rst_tx_port", {16'd0, tx_dst_port[d]}, 0);
        check_val("rst_tx_data", {24'd0, tx_data[d]}, 0);
        check_val("rst_tx_av", {31'd0, tx_data_av[d]}, 0);
        check_val("rst_tx_req", {31'd0, tx_req[d]}, 0);
        check_val("rst_echo_cnt", {16'd0, echo_cnt[d]}, 0);
        check_val("rst_drop_cnt", {16'd0, drop_cnt[d]}, 0);
    endtask

    initial begin
        bit ok;
        for (int d = 0; d < 2; d++) begin
            rx_head_av[d] = 1'b0;
            rx_head[d]    = 32'd0;
            rx_data_av[d] = 1'b0;
            rx_data[d]    = 8'd0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_idle_outputs(d);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Directed cases on the filtering MODE0 instance.
        run_frame(0, 32'hC0A80F14, 16'd5000, LISTEN0, 16'd12, 1'b0);
        run_frame(0, 32'hC0A80F14, 16'd5000, 16'd80, 16'd18, 1'b1);
        run_frame(0, 32'h0A0B0C0D, 16'd7000, LISTEN0, 16'(DEPTH + 9), 1'b1);
        run_frame(0, 32'h0A0B0C0D, 16'd7000, LISTEN0, 16'(DEPTH + 8), 1'b1);
        run_frame(0, 32'h01020304, 16'hFFFF, LISTEN0, 16'd11, 1'b1);
        run_frame(0, 32'h01020304, 16'd9, LISTEN0, 16'd8, 1'b1);
        run_frame(0, 32'h01020304, 16'd9, LISTEN0, 16'd5, 1'b1);

        // MODE1 reply port ignores src_port; any dst_port accepted.
        run_frame(1, 32'hAC100001, 16'hFFFF, 16'd80, 16'd13, 1'b1);
        run_frame(1, 32'hAC100002, 16'd42, 16'd5353, 16'd9, 1'b1);

        bp_en  = 1'b1;
        gap_en = 1'b1;
        for (int k = 0; k < 16; k++) begin
            int          d;
            logic [15:0] dport;
            logic [15:0] len;
            d     = k % 2;
            dport = ($urandom_range(0, 3) == 0) ? 16'($urandom) : LISTEN0;
            len   = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(0, 8))
                                                : 16'($urandom_range(9, DEPTH + 10));
            run_frame(d, $urandom, 16'($urandom), dport, len, 1'b1);
        end

        // Reset in the middle of a payload, then a clean frame must still echo.
        send_header(1, 32'h11223344, 16'd100, 16'd200, 16'd18, ok);
        for (int i = 0; i < 3; i++) send_byte(1, 8'(i), ok);
        rst = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        for (int d = 0; d < 2; d++) check_idle_outputs(d);
        m_echo = '{0, 0};
        m_drop = '{0, 0};
        run_frame(1, 32'h55667788, 16'd300, 16'd400, 16'd14, 1'b1);
        run_frame(0, 32'h55667789, 16'd301, LISTEN0, 16'd15, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
